// File: rtl/riscv_constants_pkg.sv
// Shared RISC-V constants: funct3 memory-access size codes and the LSU state type.
package riscv_constants;

    // funct3 size codes for loads and stores
    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align_check.sv
// Legality check for a memory access: alignment versus size, and which sizes a store may use.
module riscv_lsu_align_check
    import riscv_constants::*;
(
    input  logic [1:0] addr_lsb,
    input  logic [2:0] size,
    input  logic       write,
    output logic       legal
);

    // Byte accesses are always aligned; unsigned variants exist for loads only.
    always_comb begin
        // NOTE: default first so every path assigns legal and no latch is inferred.
        legal = 1'b0;
        case (size)
            MASK_B:  legal = 1'b1;
            MASK_BU: legal = !write;
            MASK_H:  legal = !addr_lsb[0];
            MASK_HU: legal = !write && !addr_lsb[0];
            MASK_W:  legal = (addr_lsb == 2'b00);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: issues aligned loads and stores to the memory port, waits a
// fixed read latency for load data and returns it for writeback; misaligned or
// illegal requests raise a one-cycle fault instead of touching memory.
module riscv_lsu
    import riscv_constants::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_data_in,
    input  logic [2:0]  req_size_in,
    input  logic        req_write_in,
    input  logic [4:0]  req_rd_in,
    input  logic        flush_in,
    output logic [31:0] cpu_addr_out,
    output logic [31:0] cpu_data_out,
    output logic [2:0]  cpu_size_out,
    output logic        cpu_write_enable_out,
    output logic        cpu_read_enable_out,
    input  logic [31:0] cpu_data_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_data_out,
    output logic [4:0]  resp_rd_out,
    output logic        fault_out,
    output logic [31:0] fault_addr_out
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    lsu_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       pend_rd;
    logic             legal;
    logic             accept;
    logic             issue_load;
    logic             capture;

    riscv_lsu_align_check u_align_check (
        .addr_lsb (req_addr_in[1:0]),
        .size     (req_size_in),
        .write    (req_write_in),
        .legal    (legal)
    );

    assign req_ready_out  = !rst_in && !flush_in && (state == LSU_IDLE || state == LSU_DONE);
    assign accept         = req_valid_in && req_ready_out;
    assign issue_load     = accept && legal && !req_write_in;
    assign capture        = (state == LSU_WAIT) && !flush_in && (cnt == '0);
    assign resp_valid_out = !rst_in && (state == LSU_DONE);

    // Next-state logic and the combinational memory request port.
    always_comb begin
        state_next           = state;
        cpu_addr_out         = '0;
        cpu_data_out         = '0;
        cpu_size_out         = '0;
        cpu_write_enable_out = 1'b0;
        cpu_read_enable_out  = 1'b0;

        if (accept && legal) begin
            cpu_addr_out         = req_addr_in;
            cpu_data_out         = req_write_in ? req_data_in : '0;
            cpu_size_out         = req_size_in;
            cpu_write_enable_out = req_write_in;
            cpu_read_enable_out  = !req_write_in;
        end

        case (state)
            LSU_IDLE: if (issue_load) state_next = LSU_WAIT;
            LSU_WAIT: begin
                if (flush_in)        state_next = LSU_IDLE;
                else if (cnt == '0)  state_next = LSU_DONE;
            end
            LSU_DONE: state_next = issue_load ? LSU_WAIT : LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    // State, latency counter, response capture and fault pulse.
    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            state          <= LSU_IDLE;
            cnt            <= '0;
            pend_rd        <= '0;
            resp_data_out  <= '0;
            resp_rd_out    <= '0;
            fault_out      <= 1'b0;
            fault_addr_out <= '0;
        end else begin
            state     <= state_next;
            fault_out <= accept && !legal;
            if (accept && !legal) fault_addr_out <= req_addr_in;

            if (issue_load) begin
                cnt     <= CNT_W'(READ_LATENCY - 1);
                pend_rd <= req_rd_in;
            end else if (state == LSU_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (capture) begin
                resp_data_out <= cpu_data_in;
                resp_rd_out   <= pend_rd;
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level reference model.
module tb_riscv_lsu;
    import riscv_constants::*;

    localparam int RL = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [31:0] req_addr_in;
    logic [31:0] req_data_in;
    logic [2:0]  req_size_in;
    logic        req_write_in;
    logic [4:0]  req_rd_in;
    logic        flush_in;
    logic [31:0] cpu_addr_out;
    logic [31:0] cpu_data_out;
    logic [2:0]  cpu_size_out;
    logic        cpu_write_enable_out;
    logic        cpu_read_enable_out;
    logic [31:0] cpu_data_in;
    logic        resp_valid_out;
    logic [31:0] resp_data_out;
    logic [4:0]  resp_rd_out;
    logic        fault_out;
    logic [31:0] fault_addr_out;

    always #5 clk_in = ~clk_in;

    riscv_lsu #(.READ_LATENCY(RL)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .req_valid_in         (req_valid_in),
        .req_ready_out        (req_ready_out),
        .req_addr_in          (req_addr_in),
        .req_data_in          (req_data_in),
        .req_size_in          (req_size_in),
        .req_write_in         (req_write_in),
        .req_rd_in            (req_rd_in),
        .flush_in             (flush_in),
        .cpu_addr_out         (cpu_addr_out),
        .cpu_data_out         (cpu_data_out),
        .cpu_size_out         (cpu_size_out),
        .cpu_write_enable_out (cpu_write_enable_out),
        .cpu_read_enable_out  (cpu_read_enable_out),
        .cpu_data_in          (cpu_data_in),
        .resp_valid_out       (resp_valid_out),
        .resp_data_out        (resp_data_out),
        .resp_rd_out          (resp_rd_out),
        .fault_out            (fault_out),
        .fault_addr_out       (fault_addr_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: one outstanding load with the cycle its response is due.
    bit          m_pend      = 0;
    int          m_due       = 0;
    logic [4:0]  m_pend_rd   = '0;
    logic [31:0] m_pend_data = '0;
    logic [31:0] m_resp_data = '0;
    logic [4:0]  m_resp_rd   = '0;
    bit          m_fault     = 0;
    logic [31:0] m_fault_addr = '0;

    // Memory reply scheduled by cycle number.
    logic [31:0] mem_at [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %08h expected %08h", tag, cyc, got, exp);
    endtask

    // Access is legal when its size exists, stores are signed sizes only, and the
    // address is a multiple of the access width.
    function automatic bit legal_ref(input logic [31:0] addr, input logic [2:0] size, input bit wr);
        int bytes;
        if (!(size inside {MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU})) return 0;
        if (wr && size[2]) return 0;
        bytes = 1 << size[1:0];
        return (addr % bytes) == 0;
    endfunction

    task automatic step(input bit r, input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] s, input bit w, input logic [4:0] rd, input bit f,
                        input logic [31:0] load_word);
        bit          e_wait, e_done, e_ready, acc, leg;
        logic [31:0] e_caddr, e_cdata;
        logic [2:0]  e_csize;
        bit          e_we, e_re;

        @(posedge clk_in);
        #1;
        rst_in       = r;
        req_valid_in = v;
        req_addr_in  = a;
        req_data_in  = d;
        req_size_in  = s;
        req_write_in = w;
        req_rd_in    = rd;
        flush_in     = f;
        cpu_data_in  = mem_at.exists(cyc) ? mem_at[cyc] : $urandom;

        e_wait  = m_pend && (cyc < m_due);
        e_done  = m_pend && (cyc == m_due);
        e_ready = !r && !f && !e_wait;
        acc     = v && e_ready;
        leg     = legal_ref(a, s, w);
        e_caddr = (acc && leg) ? a : '0;
        e_cdata = (acc && leg && w) ? d : '0;
        e_csize = (acc && leg) ? s : '0;
        e_we    = acc && leg && w;
        e_re    = acc && leg && !w;

        @(negedge clk_in);
        check("ready",      {31'd0, req_ready_out},        {31'd0, e_ready});
        check("resp_valid", {31'd0, resp_valid_out},       {31'd0, e_done && !r});
        check("resp_data",  resp_data_out,                 m_resp_data);
        check("resp_rd",    {27'd0, resp_rd_out},          {27'd0, m_resp_rd});
        check("fault",      {31'd0, fault_out},            {31'd0, m_fault});
        check("fault_addr", fault_addr_out,                m_fault_addr);
        check("cpu_addr",   cpu_addr_out,                  e_caddr);
        check("cpu_data",   cpu_data_out,                  e_cdata);
        check("cpu_size",   {29'd0, cpu_size_out},         {29'd0, e_csize});
        check("cpu_we",     {31'd0, cpu_write_enable_out}, {31'd0, e_we});
        check("cpu_re",     {31'd0, cpu_read_enable_out},  {31'd0, e_re});

        if (r) begin
            m_pend       = 0;
            m_resp_data  = '0;
            m_resp_rd    = '0;
            m_fault      = 0;
            m_fault_addr = '0;
        end else begin
            m_fault = acc && !leg;
            if (acc && !leg) m_fault_addr = a;
            if (e_wait && f) begin
                m_pend = 0;
            end else if (e_wait && cyc == m_due - 1) begin
                m_resp_data = m_pend_data;
                m_resp_rd   = m_pend_rd;
            end
            if (e_done) m_pend = 0;
            if (acc && leg && !w) begin
                m_pend          = 1;
                m_due           = cyc + RL + 1;
                m_pend_rd       = rd;
                m_pend_data     = load_word;
                mem_at[cyc + RL] = load_word;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 3'd0, 0, 5'd0, 0, '0);
    endtask

    initial begin
        logic [2:0] size_tab [13];
        size_tab = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU, MASK_B, MASK_H,
                     MASK_W, MASK_BU, MASK_HU, 3'b011, 3'b110, 3'b111};

        rst_in = 1'b1; req_valid_in = 1'b0; req_addr_in = '0; req_data_in = '0;
        req_size_in = '0; req_write_in = 1'b0; req_rd_in = '0; flush_in = 1'b0;
        cpu_data_in = '0;
        repeat (2) @(posedge clk_in);

        // Reset state, then directed scenarios.
        step(1, 0, '0, '0, 3'd0, 0, 5'd0, 0, '0);
        step(0, 1, 32'h100, '0, MASK_W, 0, 5'd7, 0, 32'hDEADBEEF);   // LW 0x100
        idle(4);
        step(0, 1, 32'h203, 32'hAB, MASK_B, 1, 5'd0, 0, '0);         // SB 0x203
        step(0, 1, 32'h101, '0, MASK_H, 0, 5'd2, 0, '0);             // LH misaligned
        step(0, 1, 32'h40, '0, MASK_W, 0, 5'd3, 0, 32'h12345678);    // accepted at T+1
        idle(4);
        step(0, 1, 32'h80, '0, MASK_W, 0, 5'd9, 0, 32'hCAFEF00D);    // LW then flush
        step(0, 0, '0, '0, 3'd0, 0, 5'd0, 1, '0);
        idle(5);
        step(0, 1, 32'hC0, '0, MASK_HU, 0, 5'd11, 0, 32'h0000BEEF);  // LHU then SW at DONE
        idle(2);
        step(0, 1, 32'h44, 32'h55AA55AA, MASK_W, 1, 5'd0, 0, '0);
        idle(1);
        step(0, 1, 32'h200, '0, MASK_W, 0, 5'd15, 0, 32'h0BADF00D);  // LW then reset
        step(1, 0, '0, '0, 3'd0, 0, 5'd0, 0, '0);
        idle(5);
        step(0, 1, 32'h7, 32'h1, MASK_BU, 1, 5'd0, 0, '0);           // store with BU

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] addr;
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            step(($urandom % 80) == 0, ($urandom % 4) != 0, addr, $urandom,
                 size_tab[$urandom % 13], ($urandom % 3) == 0, 5'($urandom),
                 ($urandom % 10) == 0, $urandom);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
